// File: rtl/uart_pkg.sv
// uart_pkg: UART timing constants and the TX queue drive-FSM state type, shared with the UART block
package uart_pkg;

   // 50 MHz / 115200 Bd, rounded to the nearest whole clock
   localparam int unsigned CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_DONE
   } tx_state_e;

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock byte FIFO holding storage, wrapping pointers and occupancy count
// Ports:
//   clk_i    clock, all logic on the rising edge
//   rst_ni   synchronous active-low reset; clears pointers and count, not storage
//   push_i   write request, ignored while full; data_i is the word written
//   pop_i    read request, ignored while empty; data_o always shows the head word
//   full_o   count == DEPTH
//   empty_o  count == 0
//   count_o  words currently stored, 0..DEPTH
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   // DEPTH is a power of two, so the count MSB is set only at exactly DEPTH
   assign full_o  = count_q[AW];
   assign empty_o = count_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // pointers are exactly AW bits wide, so incrementing wraps modulo DEPTH
   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = (do_push && !do_pop) ? count_q + 1'b1 :
                 (do_pop && !do_push) ? count_q - 1'b1 : count_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue in front of a UART transmitter, handing bytes over one at a time
// Ports:
//   ipClk       clock, all logic on the rising edge
//   ipReset     synchronous active-low reset
//   ipWrData    byte from the producer
//   ipWrValid   producer write request
//   opWrReady   high while the queue has room (count < DEPTH)
//   opCount     bytes currently queued, 0..DEPTH
//   opOverflow  one-cycle pulse after a write was dropped because the queue was full
//   opTxData    byte presented to the UART, held from LOAD until the next LOAD
//   opTxSend    send request to the UART, high only in SEND
//   ipTxBusy    UART busy flag
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          ipClk,
   input  logic          ipReset,
   input  logic [7:0]    ipWrData,
   input  logic          ipWrValid,
   output logic          opWrReady,
   output logic [CW-1:0] opCount,
   output logic          opOverflow,
   output logic [7:0]    opTxData,
   output logic          opTxSend,
   input  logic          ipTxBusy
);

   tx_state_e            state_q, state_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 overflow_q, overflow_d;
   logic                 pop;
   logic [7:0]           head;
   logic                 full, empty;
   logic [$clog2(DEPTH):0] fifo_count;

   fifo_sync #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (ipClk),
      .rst_ni  (ipReset),
      .push_i  (ipWrValid),
      .data_i  (ipWrData),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   assign opWrReady  = !full;
   assign opCount    = CW'(fifo_count);
   assign opOverflow = overflow_q;
   assign opTxData   = tx_data_q;
   assign opTxSend   = state_q == SEND;

   // a pop in the same edge cannot rescue a write: fullness is judged before the edge
   assign overflow_d = ipWrValid && full;

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      tx_data_d = tx_data_q;
      unique case (state_q)
         IDLE:      state_d = (!empty && !ipTxBusy) ? LOAD : IDLE;
         LOAD: begin
            // LOAD is only entered with a non-empty queue, so this pop is always honoured
            pop       = 1'b1;
            tx_data_d = head;
            state_d   = SEND;
         end
         SEND:      state_d = ipTxBusy ? WAIT_DONE : SEND;
         WAIT_DONE: state_d = ipTxBusy ? WAIT_DONE : IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge ipClk) begin
      if (!ipReset) begin
         state_q    <= IDLE;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed self-checking bench for uart_tx_queue with a behavioural UART transmitter
module tb_uart_tx_queue;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [CW-1:0] count;
   logic          overflow;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          tx_busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // UART model: latches tx_data on send while idle, then shifts start, 8 data LSB first, stop
   logic       m_busy     = 1'b0;
   logic       force_busy = 1'b0;
   logic       model_en   = 1'b0;
   int         bit_clks   = CLKS_PER_BIT;
   int         m_cnt      = 0;
   logic [3:0] m_idx      = '0;
   logic [9:0] m_frame    = '1;
   logic       tx_line;
   logic [7:0] rx_q[$];

   assign tx_busy = m_busy | force_busy;
   assign tx_line = m_busy ? m_frame[m_idx] : 1'b1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_busy) begin
         if (m_cnt == bit_clks - 1) begin
            m_cnt <= 0;
            if (m_idx == 4'd9) begin
               m_busy <= 1'b0;
               rx_q.push_back(m_frame[8:1]);
            end else m_idx <= m_idx + 4'd1;
         end else m_cnt <= m_cnt + 1;
      end else if (model_en && tx_send && !force_busy) begin
         m_busy  <= 1'b1;
         m_frame <= {1'b1, tx_data, 1'b0};
         m_idx   <= '0;
         m_cnt   <= 0;
      end
   end

   uart_tx_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .ipClk      (clk),
      .ipReset    (rst_n),
      .ipWrData   (wr_data),
      .ipWrValid  (wr_valid),
      .opWrReady  (wr_ready),
      .opCount    (count),
      .opOverflow (overflow),
      .opTxData   (tx_data),
      .opTxSend   (tx_send),
      .ipTxBusy   (tx_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int c = 0; c < budget && rx_q.size() < n; c++) tick();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_valid = 1'b0;
      wr_data = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
      total_cnt++; if (tx_send !== 1'b0) $display("FAIL reset_send got %b want 0", tx_send); else pass_cnt++;
      total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", tx_data); else pass_cnt++;
      total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (wr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", wr_ready); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
      total_cnt++; if (dut.state_q !== IDLE) $display("FAIL reset_state got %0d want IDLE", dut.state_q); else pass_cnt++;
   endtask

   task automatic test_single();
      logic [9:0] bits;
      bits = '0;
      bit_clks = CLKS_PER_BIT;
      model_en = 1'b1;
      rx_q.delete();
      push(8'hA5);
      total_cnt++; if (count !== 5'd1) $display("FAIL single_count got %0d want 1", count); else pass_cnt++;
      total_cnt++; if (tx_send !== 1'b0) $display("FAIL single_send_e0 got %b want 0", tx_send); else pass_cnt++;
      tick();
      total_cnt++; if (tx_send !== 1'b0) $display("FAIL single_send_e1 got %b want 0", tx_send); else pass_cnt++;
      tick();
      total_cnt++; if (tx_send !== 1'b1) $display("FAIL single_send_e2 got %b want 1", tx_send); else pass_cnt++;
      total_cnt++; if (tx_data !== 8'hA5) $display("FAIL single_data got %h want a5", tx_data); else pass_cnt++;
      total_cnt++; if (count !== 5'd0) $display("FAIL single_popped got %0d want 0", count); else pass_cnt++;
      tick();
      total_cnt++; if (tx_busy !== 1'b1) $display("FAIL single_uart_start got %b want 1", tx_busy); else pass_cnt++;
      for (int b = 0; b < 10; b++) begin
         repeat (CLKS_PER_BIT / 2) tick();
         bits[b] = tx_line;
         repeat (CLKS_PER_BIT - CLKS_PER_BIT / 2) tick();
      end
      total_cnt++; if (bits !== 10'b11_0100_1010) $display("FAIL single_bits got %b want 1101001010", bits); else pass_cnt++;
      total_cnt++; if (tx_busy !== 1'b0) $display("FAIL single_frame_len got busy=%b want 0", tx_busy); else pass_cnt++;
      total_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL single_rx got n=%0d want 1 byte a5", rx_q.size()); else pass_cnt++;
      total_cnt++; if (tx_data !== 8'hA5) $display("FAIL single_hold got %h want a5", tx_data); else pass_cnt++;
      repeat (4) tick();
   endtask

   task automatic test_burst();
      int maxc;
      maxc = 0;
      bit_clks = 4;
      rx_q.delete();
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         if (int'(count) > maxc) maxc = int'(count);
      end
      total_cnt++; if (maxc != 15 && maxc != 16) $display("FAIL burst_maxcount got %0d want 15 or 16", maxc); else pass_cnt++;
      wait_rx(16, 16 * (10 * 4 + 6) + 20);
      total_cnt++; if (rx_q.size() != 16) $display("FAIL burst_rx_count got %0d want 16", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         total_cnt++; if (rx_q[i] !== 8'(i)) $display("FAIL burst_byte%0d got %h want %h", i, rx_q[i], 8'(i)); else pass_cnt++;
      end
   endtask

   task automatic test_overflow();
      force_busy = 1'b1;
      bit_clks = 4;
      rx_q.delete();
      for (int i = 0; i < 15; i++) push(8'h40 + 8'(i));
      total_cnt++; if (wr_ready !== 1'b1 || count !== 5'd15) $display("FAIL ovf_at15 got ready=%b count=%0d want 1,15", wr_ready, count); else pass_cnt++;
      push(8'h4F);
      total_cnt++; if (wr_ready !== 1'b0) $display("FAIL ovf_ready got %b want 0", wr_ready); else pass_cnt++;
      total_cnt++; if (count !== 5'd16) $display("FAIL ovf_full_count got %0d want 16", count); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow); else pass_cnt++;
      push(8'hEE);
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %b want 1", overflow); else pass_cnt++;
      total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count); else pass_cnt++;
      tick();
      total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_pulse_len got %b want 0", overflow); else pass_cnt++;
      force_busy = 1'b0;
      wait_rx(16, 16 * (10 * 4 + 6) + 20);
      repeat (60) tick();
      total_cnt++; if (rx_q.size() != 16) $display("FAIL ovf_rx_count got %0d want 16", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         total_cnt++; if (rx_q[i] !== 8'h40 + 8'(i)) $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[i], 8'h40 + 8'(i)); else pass_cnt++;
      end
   endtask

   task automatic test_simul();
      bit_clks = 4;
      force_busy = 1'b1;
      rx_q.delete();
      for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
      total_cnt++; if (count !== 5'd5) $display("FAIL simul_pre got %0d want 5", count); else pass_cnt++;
      force_busy = 1'b0;
      tick();
      push(8'h65);
      total_cnt++; if (count !== 5'd5) $display("FAIL simul_count got %0d want 5", count); else pass_cnt++;
      total_cnt++; if (tx_data !== 8'h60) $display("FAIL simul_load got %h want 60", tx_data); else pass_cnt++;
      wait_rx(6, 6 * (10 * 4 + 6) + 20);
      total_cnt++; if (rx_q.size() != 6) $display("FAIL simul_rx_count got %0d want 6", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
         total_cnt++; if (rx_q[i] !== 8'h60 + 8'(i)) $display("FAIL simul_byte%0d got %h want %h", i, rx_q[i], 8'h60 + 8'(i)); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      seen = 1'b0;
      model_en = 1'b0;
      rx_q.delete();
      for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
      total_cnt++; if (dut.state_q !== SEND || count !== 5'd3) $display("FAIL rmid_pre got state=%0d count=%0d want SEND,3", dut.state_q, count); else pass_cnt++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total_cnt++; if (tx_send !== 1'b0) $display("FAIL rmid_send got %b want 0", tx_send); else pass_cnt++;
      total_cnt++; if (count !== 5'd0) $display("FAIL rmid_count got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (dut.state_q !== IDLE) $display("FAIL rmid_state got %0d want IDLE", dut.state_q); else pass_cnt++;
      total_cnt++; if (tx_data !== 8'h00) $display("FAIL rmid_data got %h want 00", tx_data); else pass_cnt++;
      model_en = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (tx_send) seen = 1'b1;
      end
      total_cnt++; if (seen !== 1'b0 || rx_q.size() != 0) $display("FAIL rmid_quiet got send_seen=%b rx=%0d want 0,0", seen, rx_q.size()); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      int errs;
      errs = 0;
      bit_clks = 2;
      rx_q.delete();
      for (int i = 0; i < 40; i++) begin
         d = 8'(i * 7 + 3);
         for (int t = 0; t < 200 && !wr_ready; t++) tick();
         push(d);
         exp_q.push_back(d);
         repeat (i % 4) tick();
      end
      wait_rx(40, 40 * (10 * 2 + 6) + 200);
      total_cnt++; if (rx_q.size() != 40) $display("FAIL wrap_rx_count got %0d want 40", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < 40 && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) errs++;
      total_cnt++; if (errs != 0) $display("FAIL wrap_order got %0d wrong bytes want 0", errs); else pass_cnt++;
      total_cnt++; if (count !== 5'd0) $display("FAIL wrap_drained got %0d want 0", count); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_simul();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
